// File: rtl/qea_host_sequencer.sv
// -----------------------------------------------------------------------------
// qea_host_sequencer
//
// Host-side job sequencer for a QEA accelerator. It accepts one job request
// and then:
//   1. streams gate-context words into the QEA context RAM,
//   2. streams the initial state vector into the QEA state RAM,
//   3. pulses o_start and waits for i_complete,
//   4. reads the final state vector back and forwards it as a result stream.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   i_go, i_ins_num, i_qbit_num    job request and its parameters
//   i_ctx_valid/o_ctx_ready/i_ctx_word   context-word input stream
//   i_st_valid/o_st_ready/i_st_word      initial-state input stream
//   o_ctx_en/o_ctx_wea/o_ctx_addr/o_ctx_data          QEA context RAM port
//   o_state_ena/o_state_wea/o_state_addra/o_state_dina QEA state RAM port
//   o_start, o_qbit_num, i_complete, i_state_dout     QEA control / readback
//   o_rd_valid, o_rd_word          result stream (no backpressure)
//   o_busy, o_done                 status
//
// Optional feature (macro QEA_SEQ_CYCLE_COUNT_EN):
//   o_exec_cycles  32-bit count of RUN cycles of the latest job.
// -----------------------------------------------------------------------------
module qea_host_sequencer #(
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_go,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_word,
    input  logic                                 i_st_valid,
    output logic                                 o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_st_word,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_rd_valid,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_word,
    output logic                                 o_busy,
`ifdef QEA_SEQ_CYCLE_COUNT_EN
    output logic [31:0]                          o_exec_cycles,
`endif
    output logic                                 o_done
);

    localparam int SW  = PE_NUM * STATE_DATA_WIDTH;
    localparam int CAW = GATE_CONTEXT_ADDR_WIDTH;
    localparam int SAW = STATE_ADDR_WIDTH;
    // One shared address counter serves both RAMs and the drain timer.
    localparam int AW  = (CAW > SAW) ? CAW : SAW;

    typedef enum logic [2:0] {
        IDLE, LOAD_CTX, LOAD_ST, START, RUN, READ, DRAIN, DONE
    } state_t;

    state_t                    state, state_nxt;
    logic [AW-1:0]             addr_cnt;
    logic [CAW-1:0]            ctx_last;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q;
    logic                      run_first;
    logic [RD_LAT-1:0]         rd_vld_p;
    logic [SAW-1:0]            st_last;
    logic                      ctx_term, st_term, drain_term;

    // Last state address = 2^(qbit-2) - 1, i.e. the low (qbit-2) bits set.
    // Saturates at all-ones when the vector exceeds the address space.
    function automatic logic [SAW-1:0] state_last_addr(input logic [MAX_QBIT_WIDTH-1:0] q);
        logic [SAW-1:0] r;
        r = '0;
        for (int i = 0; i < SAW; i++) begin
            if (i < int'(q) - 2) r[i] = 1'b1;
        end
        return r;
    endfunction

    assign st_last    = state_last_addr(qbit_q);
    assign ctx_term   = (addr_cnt == AW'(ctx_last));
    assign st_term    = (addr_cnt == AW'(st_last));
    assign drain_term = (addr_cnt == AW'(RD_LAT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (i_go) state_nxt = (i_ins_num == '0) ? LOAD_ST : LOAD_CTX;
            LOAD_CTX: if (i_ctx_valid && ctx_term) state_nxt = LOAD_ST;
            LOAD_ST:  if (i_st_valid && st_term) state_nxt = START;
            START:    state_nxt = RUN;
            // A stale i_complete from the previous job is masked in the first RUN cycle.
            RUN:      if (!run_first && i_complete) state_nxt = READ;
            READ:     if (st_term) state_nxt = DRAIN;
            DRAIN:    if (drain_term) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Job parameters, address counter and read-valid pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt  <= '0;
            ctx_last  <= '0;
            qbit_q    <= '0;
            run_first <= 1'b0;
            rd_vld_p  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_go) begin
                        addr_cnt <= '0;
                        ctx_last <= i_ins_num - 1'b1;
                        qbit_q   <= i_qbit_num;
                    end
                end
                LOAD_CTX: if (i_ctx_valid) addr_cnt <= ctx_term ? '0 : addr_cnt + AW'(1);
                LOAD_ST:  if (i_st_valid)  addr_cnt <= st_term  ? '0 : addr_cnt + AW'(1);
                READ:     addr_cnt <= st_term    ? '0 : addr_cnt + AW'(1);
                DRAIN:    addr_cnt <= drain_term ? '0 : addr_cnt + AW'(1);
                default:  addr_cnt <= addr_cnt;
            endcase
            run_first <= (state == START);
            // Read-valid travels RD_LAT stages behind each read-address cycle.
            rd_vld_p[0] <= (state == READ);
            for (int i = 1; i < RD_LAT; i++) rd_vld_p[i] <= rd_vld_p[i-1];
        end
    end

`ifdef QEA_SEQ_CYCLE_COUNT_EN
    logic [31:0] exec_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              exec_cnt <= '0;
        else if (state == START) exec_cnt <= '0;
        else if (state == RUN)   exec_cnt <= exec_cnt + 32'd1;
    end

    assign o_exec_cycles = exec_cnt;
`endif

    // Output logic
    always_comb begin
        o_ctx_ready   = 1'b0;
        o_st_ready    = 1'b0;
        o_ctx_en      = 1'b0;
        o_ctx_wea     = 1'b0;
        o_ctx_addr    = '0;
        o_ctx_data    = '0;
        o_state_ena   = 1'b0;
        o_state_wea   = 1'b0;
        o_state_addra = '0;
        o_state_dina  = '0;
        o_start       = 1'b0;
        o_done        = 1'b0;
        unique case (state)
            LOAD_CTX: begin
                o_ctx_ready = 1'b1;
                o_ctx_addr  = addr_cnt[CAW-1:0];
                if (i_ctx_valid) begin
                    o_ctx_en   = 1'b1;
                    o_ctx_wea  = 1'b1;
                    o_ctx_data = i_ctx_word;
                end
            end
            LOAD_ST: begin
                o_st_ready    = 1'b1;
                o_state_addra = addr_cnt[SAW-1:0];
                if (i_st_valid) begin
                    o_state_ena  = 1'b1;
                    o_state_wea  = 1'b1;
                    o_state_dina = i_st_word;
                end
            end
            START: o_start = 1'b1;
            READ: begin
                o_state_ena   = 1'b1;
                o_state_addra = addr_cnt[SAW-1:0];
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    assign o_busy     = (state != IDLE);
    assign o_qbit_num = qbit_q;
    assign o_rd_valid = rd_vld_p[RD_LAT-1];
    assign o_rd_word  = o_rd_valid ? i_state_dout : {SW{1'b0}};

endmodule

// File: tb/tb_qea_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_qea_host_sequencer
//
// Drives randomized jobs into qea_host_sequencer (RD_LAT = 2) with a small
// state-RAM model and a stand-in QEA that XORs every state word with MASK on
// o_start. Expected traffic is derived from the job parameters alone.
// -----------------------------------------------------------------------------
module tb_qea_host_sequencer;

    localparam int RD_LAT = 2;
    localparam int SW     = 4 * 64;
    localparam logic [SW-1:0] MASK = {(SW/32){32'hA5C3_0F96}};

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_go;
    logic [15:0]     i_ins_num;
    logic [5:0]      i_qbit_num;
    logic            i_ctx_valid, o_ctx_ready;
    logic [63:0]     i_ctx_word;
    logic            i_st_valid, o_st_ready;
    logic [SW-1:0]   i_st_word;
    logic            o_ctx_en, o_ctx_wea;
    logic [15:0]     o_ctx_addr;
    logic [63:0]     o_ctx_data;
    logic            o_state_ena, o_state_wea;
    logic [15:0]     o_state_addra;
    logic [SW-1:0]   o_state_dina;
    logic            o_start;
    logic [5:0]      o_qbit_num;
    logic            i_complete;
    logic [SW-1:0]   i_state_dout;
    logic            o_rd_valid;
    logic [SW-1:0]   o_rd_word;
    logic            o_busy, o_done;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
    logic [31:0]     o_exec_cycles;
`endif

    qea_host_sequencer #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_ins_num(i_ins_num), .i_qbit_num(i_qbit_num),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_word(i_ctx_word),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_word(i_st_word),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
        .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
        .o_state_dina(o_state_dina), .o_start(o_start), .o_qbit_num(o_qbit_num),
        .i_complete(i_complete), .i_state_dout(i_state_dout), .o_rd_valid(o_rd_valid),
        .o_rd_word(o_rd_word), .o_busy(o_busy),
`ifdef QEA_SEQ_CYCLE_COUNT_EN
        .o_exec_cycles(o_exec_cycles),
`endif
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // State RAM with RD_LAT read latency; the stand-in QEA transforms it on o_start.
    logic [SW-1:0] mem     [0:63];
    logic [SW-1:0] rd_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        if (o_start) for (int i = 0; i < 64; i++) mem[i] <= mem[i] ^ MASK;
        if (o_state_ena && o_state_wea) mem[o_state_addra[5:0]] <= o_state_dina;
        if (o_state_ena && !o_state_wea) rd_pipe[0] <= mem[o_state_addra[5:0]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_state_dout = rd_pipe[RD_LAT-1];

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0]   ctx_words [0:63];
    logic [SW-1:0] st_words  [0:63];

    // Observations of the most recent job
    int obs_ctx_wr, obs_ctx_bad, obs_st_wr, obs_st_bad, obs_start, obs_rd_addr, obs_rd_addr_bad;
    int obs_rd, obs_rd_bad, obs_busy_bad, obs_start_gap, obs_run_len, obs_done_gap, obs_qbit;
    bit obs_timeout;

    // Reference: number of state words for a qubit count
    function automatic int exp_words(input int q);
        return (q < 2) ? 1 : (1 << (q - 2));
    endfunction

    task automatic fill_words();
        for (int i = 0; i < 64; i++) begin
            ctx_words[i] = {$urandom, $urandom};
            for (int k = 0; k < SW/32; k++) st_words[i][k*32 +: 32] = $urandom;
        end
    endtask

    task automatic run_job(input int ins, input int q, input int vmode, input int dly, input bit go_in_run);
        int ci, si, s_cyc, fr_cyc, last_sw, last_rd, done_cyc, k, n_exp;
        bit fin, vbit;
        int rd_addr_cyc[$];
        n_exp = exp_words(q);
        fill_words();
        obs_ctx_wr = 0; obs_ctx_bad = 0; obs_st_wr = 0; obs_st_bad = 0; obs_start = 0;
        obs_rd_addr = 0; obs_rd_addr_bad = 0; obs_rd = 0; obs_rd_bad = 0; obs_busy_bad = 0;
        ci = 0; si = 0; s_cyc = -1; fr_cyc = -1; last_sw = -1; last_rd = -1; done_cyc = -1; fin = 0;
        @(posedge clk); #1;
        i_go = 1'b1; i_ins_num = 16'(ins); i_qbit_num = 6'(q);
        @(posedge clk); #1;
        i_go = 1'b0; i_ins_num = 16'($urandom_range(0, 60)); i_qbit_num = 6'($urandom_range(0, 63));
        for (int t = 0; t < 3000 && !fin; t++) begin
            vbit = (vmode == 0) ? 1'b1 : (vmode == 1) ? (t % 2 == 0) : 1'($urandom_range(0, 1));
            i_ctx_valid = vbit && (ci < ins);
            i_ctx_word  = (ci < ins) ? ctx_words[ci % 64] : 64'd0;
            i_st_valid  = vbit && (si < n_exp);
            i_st_word   = (si < n_exp) ? st_words[si % 64] : '0;
            k = (s_cyc >= 0) ? cyc - s_cyc : 0;
            i_complete = (k == 1) || (k == dly);
            i_go = go_in_run && (k == 3);
            if (i_go) begin i_ins_num = 16'd5; i_qbit_num = 6'd5; end
            @(negedge clk);
            if (o_ctx_en) begin
                if (!o_ctx_wea || o_ctx_addr !== 16'(obs_ctx_wr) || o_ctx_data !== ctx_words[obs_ctx_wr % 64])
                    obs_ctx_bad++;
                obs_ctx_wr++;
            end
            if (o_state_ena && o_state_wea) begin
                if (o_state_addra !== 16'(obs_st_wr) || o_state_dina !== st_words[obs_st_wr % 64])
                    obs_st_bad++;
                obs_st_wr++;
                last_sw = cyc;
            end
            if (i_ctx_valid && o_ctx_ready) ci++;
            if (i_st_valid && o_st_ready) si++;
            if (o_start) begin
                obs_start++;
                if (s_cyc < 0) s_cyc = cyc;
            end
            if (o_state_ena && !o_state_wea) begin
                if (o_state_addra !== 16'(obs_rd_addr)) obs_rd_addr_bad++;
                if (fr_cyc < 0) fr_cyc = cyc;
                rd_addr_cyc.push_back(cyc);
                obs_rd_addr++;
            end
            if (o_rd_valid) begin
                if (obs_rd < rd_addr_cyc.size()) begin
                    if (o_rd_word !== (st_words[obs_rd % 64] ^ MASK) || cyc != rd_addr_cyc[obs_rd] + RD_LAT)
                        obs_rd_bad++;
                end else obs_rd_bad++;
                obs_rd++;
                last_rd = cyc;
            end
            if (!o_busy) obs_busy_bad++;
            if (o_done) begin done_cyc = cyc; fin = 1; end
            @(posedge clk); #1;
        end
        i_go = 1'b0; i_ctx_valid = 1'b0; i_st_valid = 1'b0; i_complete = 1'b0;
        obs_timeout   = !fin;
        obs_start_gap = (s_cyc >= 0 && last_sw >= 0) ? s_cyc - last_sw : -1;
        obs_run_len   = (fr_cyc >= 0 && s_cyc >= 0) ? fr_cyc - s_cyc - 1 : -1;
        obs_done_gap  = (last_rd >= 0) ? done_cyc - last_rd : -1;
        @(negedge clk);
        obs_qbit = int'(o_qbit_num);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_go = 1'b1; i_ctx_valid = 1'b1; i_st_valid = 1'b1; i_complete = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL reset_status: busy=%b done=%b expected 0/0", o_busy, o_done);
        else n_pass++;
        n_total++;
        if ({o_ctx_ready, o_st_ready, o_ctx_en, o_state_ena, o_start, o_rd_valid} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {o_ctx_ready, o_st_ready, o_ctx_en, o_state_ena, o_start, o_rd_valid});
        else n_pass++;
        n_total++;
        if (o_qbit_num !== 6'd0 || o_ctx_addr !== 16'd0 || o_state_addra !== 16'd0)
            $display("FAIL reset_values: qbit=%0d ctx_addr=%0d st_addr=%0d expected 0", o_qbit_num, o_ctx_addr, o_state_addra);
        else n_pass++;
        i_go = 1'b0; i_ctx_valid = 1'b0; i_st_valid = 1'b0; i_complete = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_fixed_41();
        run_job(41, 3, 0, 4, 0);
        n_total++;
        if (obs_timeout) $display("FAIL f41_timeout: job did not reach done, expected done");
        else n_pass++;
        n_total++;
        if (obs_ctx_wr != 41 || obs_ctx_bad != 0) $display("FAIL f41_ctx: writes=%0d bad=%0d expected 41/0", obs_ctx_wr, obs_ctx_bad);
        else n_pass++;
        n_total++;
        if (obs_st_wr != 2 || obs_st_bad != 0) $display("FAIL f41_state: writes=%0d bad=%0d expected 2/0", obs_st_wr, obs_st_bad);
        else n_pass++;
        n_total++;
        if (obs_start != 1 || obs_start_gap != 1) $display("FAIL f41_start: pulses=%0d gap=%0d expected 1/1", obs_start, obs_start_gap);
        else n_pass++;
        n_total++;
        if (obs_rd != 2 || obs_rd_bad != 0 || obs_rd_addr_bad != 0)
            $display("FAIL f41_read: words=%0d bad=%0d addr_bad=%0d expected 2/0/0", obs_rd, obs_rd_bad, obs_rd_addr_bad);
        else n_pass++;
        n_total++;
        if (obs_busy_bad != 0 || obs_qbit != 3) $display("FAIL f41_status: busy_low=%0d qbit=%0d expected 0/3", obs_busy_bad, obs_qbit);
        else n_pass++;
    endtask

    task automatic test_toggle_valid();
        run_job(41, 2, 1, 3, 0);
        n_total++;
        if (obs_ctx_wr != 41 || obs_ctx_bad != 0) $display("FAIL toggle_ctx: writes=%0d bad=%0d expected 41/0", obs_ctx_wr, obs_ctx_bad);
        else n_pass++;
        n_total++;
        if (obs_st_wr != 1 || obs_rd != 1 || obs_rd_bad != 0)
            $display("FAIL toggle_state: wr=%0d rd=%0d bad=%0d expected 1/1/0", obs_st_wr, obs_rd, obs_rd_bad);
        else n_pass++;
    endtask

    task automatic test_zero_ins();
        run_job(0, 1, 0, 2, 0);
        n_total++;
        if (obs_ctx_wr != 0) $display("FAIL zero_ctx: writes=%0d expected 0", obs_ctx_wr);
        else n_pass++;
        n_total++;
        if (obs_st_wr != 1 || obs_st_bad != 0 || obs_rd_addr != 1 || obs_rd != 1 || obs_rd_bad != 0)
            $display("FAIL zero_state: wr=%0d bad=%0d raddr=%0d rd=%0d rbad=%0d expected 1/0/1/1/0",
                     obs_st_wr, obs_st_bad, obs_rd_addr, obs_rd, obs_rd_bad);
        else n_pass++;
    endtask

    task automatic test_complete_delay();
        run_job(3, 2, 0, 10, 0);
        n_total++;
        if (obs_run_len != 10) $display("FAIL run_length: got %0d cycles expected 10", obs_run_len);
        else n_pass++;
`ifdef QEA_SEQ_CYCLE_COUNT_EN
        n_total++;
        if (o_exec_cycles !== 32'd10) $display("FAIL exec_cycles: got %0d expected 10", o_exec_cycles);
        else n_pass++;
`endif
    endtask

    task automatic test_rdlat_q4();
        run_job(2, 4, 0, 3, 0);
        n_total++;
        if (obs_rd_addr != 4 || obs_rd_addr_bad != 0) $display("FAIL q4_raddr: count=%0d bad=%0d expected 4/0", obs_rd_addr, obs_rd_addr_bad);
        else n_pass++;
        n_total++;
        if (obs_rd != 4 || obs_rd_bad != 0) $display("FAIL q4_rdata: words=%0d bad=%0d expected 4/0", obs_rd, obs_rd_bad);
        else n_pass++;
        n_total++;
        if (obs_done_gap != 1) $display("FAIL q4_done: gap=%0d expected 1", obs_done_gap);
        else n_pass++;
    endtask

    task automatic test_go_in_run();
        int busy_after;
        run_job(3, 2, 0, 6, 1);
        n_total++;
        if (obs_rd != 1 || obs_qbit != 2 || obs_timeout)
            $display("FAIL go_in_run_job: words=%0d qbit=%0d timeout=%0d expected 1/2/0", obs_rd, obs_qbit, obs_timeout);
        else n_pass++;
        busy_after = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (o_busy) busy_after++;
        end
        n_total++;
        if (busy_after != 0) $display("FAIL go_in_run_ignored: busy cycles after done=%0d expected 0", busy_after);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit seen;
        int activity;
        fill_words();
        @(posedge clk); #1;
        i_go = 1'b1; i_ins_num = 16'd2; i_qbit_num = 6'd4;
        @(posedge clk); #1;
        i_go = 1'b0; i_ctx_valid = 1'b1; i_st_valid = 1'b1;
        i_ctx_word = ctx_words[0]; i_st_word = st_words[0];
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (o_st_ready) seen = 1;
        end
        n_total++;
        if (!seen) $display("FAIL abort_reach_load_st: reached=%0d expected 1", seen);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (o_busy !== 1'b0 || o_st_ready !== 1'b0 || o_state_ena !== 1'b0 || o_qbit_num !== 6'd0)
            $display("FAIL abort_async: busy=%b ready=%b ena=%b qbit=%0d expected 0", o_busy, o_st_ready, o_state_ena, o_qbit_num);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        activity = 0;
        for (int t = 0; t < 12; t++) begin
            i_complete = t[0];
            @(negedge clk);
            if (o_busy || o_ctx_en || o_state_ena || o_start || o_rd_valid) activity++;
        end
        n_total++;
        if (activity != 0) $display("FAIL abort_quiet: active cycles=%0d expected 0", activity);
        else n_pass++;
        i_ctx_valid = 1'b0; i_st_valid = 1'b0; i_complete = 1'b0;
        run_job(7, 3, 2, 3, 0);
        n_total++;
        if (obs_ctx_wr != 7 || obs_ctx_bad != 0 || obs_rd != 2 || obs_rd_bad != 0 || obs_timeout)
            $display("FAIL abort_clean_job: ctx=%0d cbad=%0d rd=%0d rbad=%0d timeout=%0d expected 7/0/2/0/0",
                     obs_ctx_wr, obs_ctx_bad, obs_rd, obs_rd_bad, obs_timeout);
        else n_pass++;
    endtask

    task automatic test_random();
        int ins, q, dly, n;
        for (int it = 0; it < 6; it++) begin
            ins = $urandom_range(0, 50);
            q   = $urandom_range(0, 5);
            dly = $urandom_range(2, 12);
            n   = exp_words(q);
            run_job(ins, q, 2, dly, 0);
            n_total++;
            if (obs_ctx_wr != ins || obs_ctx_bad != 0 || obs_st_wr != n || obs_st_bad != 0)
                $display("FAIL rand%0d_load: ctx=%0d cbad=%0d st=%0d sbad=%0d expected %0d/0/%0d/0",
                         it, obs_ctx_wr, obs_ctx_bad, obs_st_wr, obs_st_bad, ins, n);
            else n_pass++;
            n_total++;
            if (obs_rd_addr != n || obs_rd_addr_bad != 0 || obs_rd != n || obs_rd_bad != 0)
                $display("FAIL rand%0d_read: raddr=%0d abad=%0d rd=%0d rbad=%0d expected %0d/0/%0d/0",
                         it, obs_rd_addr, obs_rd_addr_bad, obs_rd, obs_rd_bad, n, n);
            else n_pass++;
            n_total++;
            if (obs_start_gap != 1 || obs_run_len != dly || obs_done_gap != 1 || obs_qbit != q)
                $display("FAIL rand%0d_timing: start_gap=%0d run=%0d done_gap=%0d qbit=%0d expected 1/%0d/1/%0d",
                         it, obs_start_gap, obs_run_len, obs_done_gap, obs_qbit, dly, q);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; i_go = 1'b0; i_ins_num = '0; i_qbit_num = '0;
        i_ctx_valid = 1'b0; i_ctx_word = '0; i_st_valid = 1'b0; i_st_word = '0; i_complete = 1'b0;
        test_reset();
        test_fixed_41();
        test_toggle_valid();
        test_zero_ins();
        test_complete_delay();
        test_rdlat_q4();
        test_go_in_run();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
